// File: rtl/booth_pkg.sv
// Shared definitions for the time-shared Booth multiplier:
// the controller state encoding and the default operand width.
package booth_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : booth_pkg

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract the sign-extended multiplicand,
// then shift {A,Q,Q(-1)} right arithmetically by one bit.
module booth_step
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             qm1,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   a_sh,
   output logic [WIDTH-1:0] q_sh,
   output logic             qm1_sh
);

   logic [WIDTH:0] m_ext_s;
   logic [WIDTH:0] sum_s;

   // One extra bit keeps the most negative multiplicand representable after negation.
   assign m_ext_s = {m[WIDTH-1], m};

   // Booth recoding of the current multiplier bit pair.
   always_comb begin
      sum_s = a;
      case ({q[0], qm1})
         2'b10:   sum_s = a - m_ext_s;
         2'b01:   sum_s = a + m_ext_s;
         default: sum_s = a;
      endcase
   end

   assign a_sh   = {sum_s[WIDTH], sum_s[WIDTH:1]};
   assign q_sh   = {sum_s[0], q[WIDTH-1:1]};
   assign qm1_sh = q[0];

endmodule : booth_step

// File: rtl/booth_shared_mul.sv
// Signed Booth multiplier shared between two requesters through a
// round-robin arbiter; one iteration per clock, result held until consumed.
module booth_shared_mul
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_m,
   input  logic [WIDTH-1:0]   req0_q,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_m,
   input  logic [WIDTH-1:0]   req1_q,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_prod,
   output logic               res_id,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t               state_r;
   logic [WIDTH-1:0]     m_r;
   logic [WIDTH-1:0]     q_r;
   logic [WIDTH:0]       a_r;
   logic                 qm1_r;
   logic [CW-1:0]        cnt_r;
   logic                 id_r;
   logic                 last_served_r;
   logic                 res_valid_r;
   logic                 res_id_r;
   logic [2*WIDTH-1:0]   res_prod_r;

   logic                 grant_s;
   logic                 hs_s;
   logic [WIDTH:0]       a_sh_s;
   logic [WIDTH-1:0]     q_sh_s;
   logic                 qm1_sh_s;

   // Round-robin grant: a lone requester wins, contention favours the one not served last.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_served_r;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign req0_ready = (state_r == IDLE) && req0_valid && !grant_s;
   assign req1_ready = (state_r == IDLE) && req1_valid && grant_s;
   assign hs_s       = req0_ready | req1_ready;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a      (a_r),
      .q      (q_r),
      .qm1    (qm1_r),
      .m      (m_r),
      .a_sh   (a_sh_s),
      .q_sh   (q_sh_s),
      .qm1_sh (qm1_sh_s)
   );

   // Controller and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         m_r           <= '0;
         q_r           <= '0;
         a_r           <= '0;
         qm1_r         <= 1'b0;
         cnt_r         <= '0;
         id_r          <= 1'b0;
         last_served_r <= 1'b1;
         res_valid_r   <= 1'b0;
         res_id_r      <= 1'b0;
         res_prod_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (hs_s) begin
                  m_r           <= grant_s ? req1_m : req0_m;
                  q_r           <= grant_s ? req1_q : req0_q;
                  a_r           <= '0;
                  qm1_r         <= 1'b0;
                  cnt_r         <= CW'(WIDTH);
                  id_r          <= grant_s;
                  last_served_r <= grant_s;
                  state_r       <= STEP;
               end
            end
            STEP: begin
               a_r   <= a_sh_s;
               q_r   <= q_sh_s;
               qm1_r <= qm1_sh_s;
               cnt_r <= cnt_r - CW'(1);
               // The result is published only on entry to DONE so it stays stable elsewhere.
               if (cnt_r == CW'(1)) begin
                  res_prod_r  <= {a_sh_s[WIDTH-1:0], q_sh_s};
                  res_id_r    <= id_r;
                  res_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign res_valid = res_valid_r;
   assign res_prod  = res_prod_r;
   assign res_id    = res_id_r;
   assign busy      = (state_r != IDLE);

endmodule : booth_shared_mul

// File: tb/tb_booth_shared_mul.sv
// Self-checking bench for booth_shared_mul: directed cases, arbitration,
// back-pressure, mid-operation reset and a randomized exhaustive sweep.
module tb_booth_shared_mul;

   localparam int W  = 4;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]  req0_m, req0_q, req1_m, req1_q;
   logic          res_valid, res_ready, res_id, busy;
   logic [PW-1:0] res_prod;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   booth_shared_mul #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_m     (req0_m),
      .req0_q     (req0_q),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_m     (req1_m),
      .req1_q     (req1_q),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_prod   (res_prod),
      .res_id     (res_id),
      .busy       (busy)
   );

   // Reference: plain signed integer multiplication truncated to the product width.
   function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
      int a;
      int b;
      a = $signed(m);
      b = $signed(q);
      return PW'(a * b);
   endfunction

   // Present an operand pair, wait for its handshake edge, then withdraw and scramble operands.
   task automatic start_op(input logic id, input logic [W-1:0] m, input logic [W-1:0] q, output bit ok);
      int n;
      @(negedge clk);
      if (id) begin
         req1_valid = 1'b1; req1_m = m; req1_q = q;
      end else begin
         req0_valid = 1'b1; req0_m = m; req0_q = q;
      end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = (n < 40);
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      req0_m = W'($urandom); req0_q = W'($urandom);
      req1_m = W'($urandom); req1_q = W'($urandom);
   endtask

   // Count falling edges after the handshake until res_valid is seen.
   task automatic wait_result(output int lat, output bit ok);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!res_valid && lat < 40);
      ok = res_valid;
   endtask

   // Accept the product at the current falling edge.
   task automatic retire(output logic [PW-1:0] prod, output logic id);
      res_ready = 1'b1;
      prod = res_prod;
      id = res_id;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
      req0_m = '0; req0_q = '0; req1_m = '0; req1_q = '0;
      #3;
      checks++;
      if ({busy, res_valid, res_id} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got busy=%b valid=%b id=%b exp 0 0 0", busy, res_valid, res_id);
      end
      checks++;
      if (res_prod !== 8'h00) begin
         errors++; $display("FAIL reset_prod got %h exp 00", res_prod);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0]  ms [4] = '{4'd3, 4'h8, 4'h8, 4'd7};
      logic [W-1:0]  qs [4] = '{4'hE, 4'h8, 4'd7, 4'd7};
      logic          ids[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [PW-1:0] exp[4] = '{8'hFA, 8'h40, 8'hC8, 8'h31};
      logic [PW-1:0] prod;
      logic          id;
      int            lat;
      bit            ok;
      for (int i = 0; i < 4; i++) begin
         start_op(ids[i], ms[i], qs[i], ok);
         checks++;
         if (!ok || busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL dir_start[%0d] got ok=%b busy=%b valid=%b exp 1 1 0", i, ok, busy, res_valid);
         end
         wait_result(lat, ok);
         checks++;
         if (!ok || lat != W + 1) begin
            errors++; $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, W + 1);
         end
         retire(prod, id);
         checks++;
         if (prod !== exp[i] || id !== ids[i]) begin
            errors++; $display("FAIL dir_prod[%0d] got %h id %b exp %h id %b", i, prod, id, exp[i], ids[i]);
         end
      end
   endtask

   task automatic test_arbitration();
      logic [PW-1:0] prod;
      logic          id;
      int            lat;
      bit            ok;
      apply_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_m = 4'd2; req0_q = 4'd3;
      req1_valid = 1'b1; req1_m = 4'hF; req1_q = 4'hF;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL arb_first got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      wait_result(lat, ok);
      retire(prod, id);
      checks++;
      if (!ok || prod !== 8'h06 || id !== 1'b0) begin
         errors++; $display("FAIL arb_prod0 got %h id %b exp 06 id 0", prod, id);
      end
      req0_valid = 1'b1; req0_m = 4'd5; req0_q = 4'hD;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL arb_second got r0=%b r1=%b exp 0 1", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      wait_result(lat, ok);
      retire(prod, id);
      checks++;
      if (!ok || prod !== 8'h01 || id !== 1'b1) begin
         errors++; $display("FAIL arb_prod1 got %h id %b exp 01 id 1", prod, id);
      end
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL arb_third got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      wait_result(lat, ok);
      retire(prod, id);
      checks++;
      if (!ok || prod !== 8'hF1 || id !== 1'b0) begin
         errors++; $display("FAIL arb_prod2 got %h id %b exp f1 id 0", prod, id);
      end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] prod;
      logic          id;
      int            lat;
      bit            ok;
      start_op(1'b1, 4'd6, 4'h9, ok);
      wait_result(lat, ok);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if (res_valid !== 1'b1 || res_prod !== 8'hD6 || res_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%b p=%h id=%b r0=%b r1=%b exp 1 d6 1 0 0",
                     k, res_valid, res_prod, res_id, req0_ready, req1_ready);
         end
      end
      @(negedge clk);
      retire(prod, id);
      checks++;
      if (prod !== 8'hD6 || id !== 1'b1) begin
         errors++; $display("FAIL bp_retire got %h id %b exp d6 id 1", prod, id);
      end
      checks++;
      if (res_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL bp_after got v=%b r0=%b r1=%b exp 0 1 0", res_valid, req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid_step();
      logic [PW-1:0] prod;
      logic          id;
      int            lat;
      bit            ok;
      bit            seen;
      start_op(1'b0, 4'd3, 4'd3, ok);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid got busy=%b valid=%b exp 0 0", busy, res_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (res_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL rst_discard got activity=1 exp 0");
      end
      start_op(1'b1, 4'hD, 4'd5, ok);
      wait_result(lat, ok);
      checks++;
      if (!ok || lat != W + 1) begin
         errors++; $display("FAIL rst_next_latency got %0d exp %0d", lat, W + 1);
      end
      retire(prod, id);
      checks++;
      if (prod !== 8'hF1 || id !== 1'b1) begin
         errors++; $display("FAIL rst_next_prod got %h id %b exp f1 id 1", prod, id);
      end
   endtask

   task automatic test_sweep();
      logic [PW-1:0] prod;
      logic [PW-1:0] exp;
      logic          id;
      logic          want_id;
      logic [7:0]    pair;
      int            lat;
      int            dly;
      bit            ok;
      for (int i = 0; i < 256; i++) begin
         pair = 8'(i);
         want_id = pair[0];
         exp = ref_prod(pair[7:4], pair[3:0]);
         start_op(want_id, pair[7:4], pair[3:0], ok);
         wait_result(lat, ok);
         checks++;
         if (!ok || lat != W + 1) begin
            errors++; $display("FAIL sweep_latency[%0d] got %0d exp %0d", i, lat, W + 1);
         end
         dly = int'($urandom_range(0, 3));
         repeat (dly) @(negedge clk);
         retire(prod, id);
         checks++;
         if (prod !== exp || id !== want_id) begin
            errors++; $display("FAIL sweep_prod[%0d] got %h id %b exp %h id %b", i, prod, id, exp, want_id);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_directed();
      test_arbitration();
      test_backpressure();
      test_reset_mid_step();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_booth_shared_mul
